// File: rtl/data_mem_fetch_ctrl_pkg.sv
// Shared types and sizing for the Winograd data-memory fetch path.
package winocnn_mem_pkg;
    localparam int ADDR_W    = 8;
    localparam int MEM_DEPTH = 128;
    localparam int CNT_W     = 8;
    localparam int TILE_ROWS = 4;

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} fetch_state_e;
endpackage

// File: rtl/data_mem_fetch_ctrl_if.sv
// Control/config/status bundle between the layer controller and the fetch sequencer.
interface data_mem_fetch_ctrl_if;
    import winocnn_mem_pkg::*;

    logic              scan_mode;
    logic              start;
    logic [ADDR_W-1:0] cfg_base_addr;
    logic [ADDR_W-1:0] cfg_tile_stride;
    logic [CNT_W-1:0]  cfg_num_tiles;
    logic              stall_in;
    logic [ADDR_W-1:0] addr_1_in;
    logic [ADDR_W-1:0] addr_2_in;
    logic              package_1_valid;
    logic              package_2_valid;
    logic [CNT_W-1:0]  tile_idx;
    logic              busy;
    logic              done;
    logic              aborted;
    logic              oob_err;

    modport master (
        input  scan_mode, start, cfg_base_addr, cfg_tile_stride, cfg_num_tiles, stall_in,
        output addr_1_in, addr_2_in, package_1_valid, package_2_valid,
               tile_idx, busy, done, aborted, oob_err
    );

    modport slave (
        output scan_mode, start, cfg_base_addr, cfg_tile_stride, cfg_num_tiles, stall_in,
        input  addr_1_in, addr_2_in, package_1_valid, package_2_valid,
               tile_idx, busy, done, aborted, oob_err
    );
endinterface

// File: rtl/data_mem_fetch_ctrl_addr_gen.sv
// Tile base accumulator plus per-port row address and bounds check for one beat.
module fetch_addr_gen
    import winocnn_mem_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   load_i,
    input  logic [ADDR_W-1:0]      base_i,
    input  logic                   advance_i,
    input  logic [ADDR_W-1:0]      stride_i,
    input  logic                   hi_i,
    output logic [1:0][ADDR_W-1:0] addr_o,
    output logic [1:0]             inb_o
);
    localparam int ROW_W = ADDR_W + 2;

    logic [ADDR_W:0]  tbase_q, tbase_d;
    logic [ROW_W-1:0] step_sum;

    // Saturate instead of wrapping so a runaway base can never alias back into range.
    always_comb begin
        step_sum = {1'b0, tbase_q} + ROW_W'(stride_i);
        tbase_d  = tbase_q;
        if (load_i)
            tbase_d = {1'b0, base_i};
        else if (advance_i)
            tbase_d = step_sum[ROW_W-1] ? '1 : step_sum[ADDR_W:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            tbase_q <= '0;
        else
            tbase_q <= tbase_d;
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            logic [ROW_W-1:0] row;
            assign row = {1'b0, tbase_q}
                       + (hi_i ? ROW_W'(TILE_ROWS / 2) : ROW_W'(0))
                       + ROW_W'(gi);
            assign inb_o[gi]  = (row < ROW_W'(MEM_DEPTH)) && (row < ROW_W'(1 << ADDR_W));
            assign addr_o[gi] = row[ADDR_W-1:0];
        end
    endgenerate
endmodule

// File: rtl/data_mem_fetch_ctrl.sv
// Dual-port row-read sequencer: walks tiles as LO/HI beats, yields to scan loading.
module data_mem_fetch_ctrl
    import winocnn_mem_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    data_mem_fetch_ctrl_if.master bus
);
    fetch_state_e            state_q, state_d;
    logic [ADDR_W-1:0]       stride_q, stride_d;
    logic [CNT_W-1:0]        num_q, num_d;
    logic [CNT_W-1:0]        tile_cnt_q, tile_cnt_d;
    logic [1:0][ADDR_W-1:0]  addr_q, addr_d;
    logic [1:0]              vld_q, vld_d;
    logic [CNT_W-1:0]        tile_idx_q, tile_idx_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    aborted_q, aborted_d;
    logic                    oob_q, oob_d;

    logic                    gen_load, gen_adv;
    logic [1:0][ADDR_W-1:0]  row_addr;
    logic [1:0]              row_inb;

    fetch_addr_gen u_addr_gen (
        .clk       (clk),
        .reset_n   (reset_n),
        .load_i    (gen_load),
        .base_i    (bus.cfg_base_addr),
        .advance_i (gen_adv),
        .stride_i  (stride_q),
        .hi_i      (state_q == HI),
        .addr_o    (row_addr),
        .inb_o     (row_inb)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            stride_q   <= '0;
            num_q      <= '0;
            tile_cnt_q <= '0;
            addr_q     <= '0;
            vld_q      <= '0;
            tile_idx_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
            oob_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            stride_q   <= stride_d;
            num_q      <= num_d;
            tile_cnt_q <= tile_cnt_d;
            addr_q     <= addr_d;
            vld_q      <= vld_d;
            tile_idx_q <= tile_idx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            aborted_q  <= aborted_d;
            oob_q      <= oob_d;
        end
    end

    // state_q names the beat to be registered at the next edge; the output
    // registers always hold the beat currently presented downstream.
    always_comb begin
        state_d    = state_q;
        stride_d   = stride_q;
        num_d      = num_q;
        tile_cnt_d = tile_cnt_q;
        addr_d     = addr_q;
        vld_d      = vld_q;
        tile_idx_d = tile_idx_q;
        busy_d     = busy_q;
        oob_d      = oob_q;
        done_d     = 1'b0;
        aborted_d  = 1'b0;
        gen_load   = 1'b0;
        gen_adv    = 1'b0;

        if (bus.scan_mode && state_q != IDLE) begin
            state_d   = IDLE;
            vld_d     = '0;
            addr_d    = '0;
            busy_d    = 1'b0;
            aborted_d = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.start && !bus.scan_mode) begin
                        gen_load   = 1'b1;
                        stride_d   = bus.cfg_tile_stride;
                        num_d      = bus.cfg_num_tiles;
                        tile_cnt_d = '0;
                        tile_idx_d = '0;
                        oob_d      = 1'b0;
                        state_d    = (bus.cfg_num_tiles == '0) ? DONE : LO;
                    end
                end
                LO, HI: begin
                    if (!bus.stall_in) begin
                        for (int p = 0; p < 2; p++) begin
                            vld_d[p]  = row_inb[p];
                            addr_d[p] = row_inb[p] ? row_addr[p] : '0;
                        end
                        oob_d      = oob_q | ~(&row_inb);
                        tile_idx_d = tile_cnt_q;
                        busy_d     = 1'b1;
                        if (state_q == LO) begin
                            state_d = HI;
                        end else begin
                            gen_adv = 1'b1;
                            if (tile_cnt_q == num_q - CNT_W'(1)) begin
                                state_d = DONE;
                            end else begin
                                tile_cnt_d = tile_cnt_q + CNT_W'(1);
                                state_d    = LO;
                            end
                        end
                    end
                end
                DONE: begin
                    // The last beat is still on the bus here and must survive a stall.
                    if (!(bus.stall_in && (|vld_q))) begin
                        vld_d   = '0;
                        addr_d  = '0;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.addr_1_in       = addr_q[0];
    assign bus.addr_2_in       = addr_q[1];
    assign bus.package_1_valid = vld_q[0];
    assign bus.package_2_valid = vld_q[1];
    assign bus.tile_idx        = tile_idx_q;
    assign bus.busy            = busy_q;
    assign bus.done            = done_q;
    assign bus.aborted         = aborted_q;
    assign bus.oob_err         = oob_q;
endmodule
